// File: rtl/usb_pkg.sv
// Shared USB TX definitions: line states, their {dp,dm} encodings and token/data PIDs.
package usb_pkg;

    typedef enum logic [1:0] {BUS_J, BUS_K, BUS_SE0} bus_state_t;

    localparam logic [1:0] J_DP_DM   = 2'b10;
    localparam logic [1:0] K_DP_DM   = 2'b01;
    localparam logic [1:0] SE0_DP_DM = 2'b00;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic logic [1:0] bus_dp_dm(input bus_state_t s);
        case (s)
            BUS_K:   return K_DP_DM;
            BUS_SE0: return SE0_DP_DM;
            default: return J_DP_DM;
        endcase
    endfunction

endpackage

// File: rtl/nrzi_eop_driver_nrzi_enc.sv
// NRZI level register (1 = J, 0 = K): a 0 bit toggles, a 1 bit holds; load_j rebases to J.
// level_next is combinational so the caller can register the encoded symbol in the same edge.
module nrzi_enc (
    input  logic clk,
    input  logic rst,
    input  logic load_j,
    input  logic enc_en,
    input  logic bit_in,
    output logic level_next
);

    logic level;

    assign level_next = (load_j ? 1'b1 : level) ^ (enc_en & ~bit_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b1;
        end else begin
            level <= level_next;
        end
    end

endmodule

// File: rtl/nrzi_eop_driver.sv
// NRZI-encodes the stuffed TX bit stream onto dp/dm, appends SE0/J end-of-packet and releases the bus.
// One cycle of latency from bit_in to dp/dm; never stalls, all outputs registered.
module nrzi_eop_driver
    import usb_pkg::*;
#(
    parameter int EOP_SE0_CYCLES = 2,
    parameter int EOP_J_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic start,
    input  logic last,
    output logic dp,
    output logic dm,
    output logic drive_en,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {IDLE, XMIT, EOP_SE0, EOP_J} tx_state_t;

    localparam logic [2:0] SE0_LOAD = 3'(EOP_SE0_CYCLES - 1);
    localparam logic [2:0] J_LOAD   = 3'(EOP_J_CYCLES - 1);

    tx_state_t  state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    bus_state_t bus_nxt;
    logic       drive_nxt, busy_nxt, done_nxt;
    logic       load_j, enc_en, level_next;

    nrzi_enc u_nrzi_enc (
        .clk        (clk),
        .rst        (rst),
        .load_j     (load_j),
        .enc_en     (enc_en),
        .bit_in     (bit_in),
        .level_next (level_next)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bus_nxt   = BUS_J;
        drive_nxt = 1'b1;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        load_j    = 1'b0;
        enc_en    = 1'b0;
        case (state)
            IDLE: begin
                load_j    = 1'b1;
                drive_nxt = 1'b0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
                // drive_en still high here means this edge is the release edge
                done_nxt  = drive_en;
                if (start && !drive_en) begin
                    enc_en    = 1'b1;
                    drive_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    bus_nxt   = level_next ? BUS_J : BUS_K;
                    state_nxt = last ? EOP_SE0 : XMIT;
                    cnt_nxt   = SE0_LOAD;
                end
            end
            XMIT: begin
                enc_en  = 1'b1;
                bus_nxt = level_next ? BUS_J : BUS_K;
                if (last) begin
                    state_nxt = EOP_SE0;
                    cnt_nxt   = SE0_LOAD;
                end
            end
            EOP_SE0: begin
                bus_nxt = BUS_SE0;
                if (cnt == 3'd0) begin
                    state_nxt = EOP_J;
                    cnt_nxt   = J_LOAD;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            EOP_J: begin
                bus_nxt = BUS_J;
                if (cnt == 3'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            {dp, dm} <= J_DP_DM;
            drive_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            {dp, dm} <= bus_dp_dm(bus_nxt);
            drive_en <= drive_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: doc/nrzi_eop_driver.md
Name: nrzi_eop_driver

Overview:
- Transmit-side stage directly downstream of bitStuffer in the USB host TX path.
- Takes the stuffed serial bit stream and NRZI-encodes it onto the differential pair.
- Appends End-Of-Packet: SE0 for EOP_SE0_CYCLES cycles, then J for EOP_J_CYCLES cycles.
- Controls bus drive enable and reports packet completion to the protocol FSM.

Parameters:
- EOP_SE0_CYCLES, 2, number of SE0 bit times in EOP (legal range 1..7).
- EOP_J_CYCLES, 1, number of driven J bit times after SE0 before release (legal range 1..7).

Ports:
- clk  input  1  system clock, one bit time per cycle.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  stuffed bit from bitStuffer, valid every cycle while a packet is in flight.
- start  input  1  marks first bit of packet (first SYNC bit) on bit_in.
- last  input  1  marks final stuffed bit of packet on bit_in.
- dp  output  1  D+ line value.
- dm  output  1  D- line value.
- drive_en  output  1  1 = transceiver drives dp/dm; 0 = bus released.
- busy  output  1  1 from packet acceptance until bus release.
- done  output  1  one-cycle pulse on the cycle the bus is released.

Behaviour:
- Reset is synchronous and active-high; there is one clock.
- Line encodings ({dp,dm}): J=10, K=01, SE0=00 (full speed).
- All outputs are registered. Reset values: dp=1, dm=0, drive_en=0, busy=0, done=0, FSM=IDLE, NRZI level=J.
- Latency: bit_in sampled at edge n appears on dp/dm after edge n+1 (1 cycle).
- NRZI: bit 0 toggles the line level (J<->K); bit 1 holds it. The level register is forced to J on the cycle start is accepted, so the first bit is encoded relative to J.
- FSM states: IDLE, XMIT, EOP_SE0, EOP_J.
- IDLE:
  - dp/dm=J, drive_en=0, busy=0.
  - start=1 -> XMIT; the first bit is encoded immediately; drive_en=1 and busy=1 from the next edge.
- XMIT:
  - Encode every cycle, no gaps. bitStuffer's stall applies upstream only; this block never stalls.
  - last=1 -> the final bit is encoded; next state is EOP_SE0.
- start and last in the same cycle (single-bit packet): encode that bit, then go to EOP_SE0.
- EOP_SE0:
  - dp/dm=SE0, drive_en=1, counter counts EOP_SE0_CYCLES cycles, then EOP_J.
  - bit_in, start and last are ignored.
- EOP_J:
  - dp/dm=J, drive_en=1, counts EOP_J_CYCLES cycles, then IDLE.
  - On entry to IDLE: done=1 for one cycle, drive_en=0, busy=0.
- start while busy (XMIT/EOP states) is ignored; no restart or re-sync.
- last while in IDLE without start is ignored.
- rst mid-packet: on the next edge FSM=IDLE, drive_en=0, dp/dm=J, done is not pulsed, and the EOP counter is cleared.
- Counters are 3 bits wide, count down from parameter-1, and never wrap; the state advances at 0.
- A new start is accepted on the same cycle done is asserted (back-to-back packets).

Decomposition:
- usb_pkg (shared package) holds:
  - typedef enum logic [1:0] {BUS_J, BUS_K, BUS_SE0} bus_state_t.
  - Encoding constants J_DP_DM=2'b10, K_DP_DM=2'b01, SE0_DP_DM=2'b00.
  - PID constants shared with bitStreamEncoder.
- The TX FSM state enum is local to the module.
- Optional sub-module nrzi_enc: level register with toggle-on-0 and synchronous load-to-J. Everything else stays in nrzi_eop_driver.

Test Plan:
- SYNC: start at bit 0 with stream 00000001, then last on the final 1 -> {dp,dm} = K,J,K,J,K,J,K,K, then SE0,SE0,J, then release (drive_en 0, done pulse on that cycle); busy high for 11 cycles.
- Stuffed run: bits 0,1,1,1,1,1,1,0 (stuffed zero) with last on the final 0 -> K,K,K,K,K,K,K,J, then SE0,SE0,J; confirms the 1-cycle latency against a reference model.
- Single-bit packet: start=last=1 with bit_in=1 -> J (driven), SE0, SE0, J, release; done after 4 driven cycles.
- Reset mid-packet: assert rst at the 5th XMIT bit -> next cycle drive_en=0, {dp,dm}=10, busy=0, no done; a following start encodes from J.
- Back-to-back / ignored start: start pulse during EOP_SE0 is ignored; start on the done cycle begins the next packet immediately with no idle gap, and the first bit 0 produces K.
- Parameter sweep: EOP_SE0_CYCLES=3, EOP_J_CYCLES=2 -> exactly 3 SE0 and 2 J cycles before release.
